mem_port_arbiter: RTL and testbench

- Shares the single data-memory port between two requesters: instruction fetch (I) and load/store (D).
- Runs a small request/response state machine with one outstanding transaction.
- Gives D priority, but prevents fetch starvation with a streak counter.
- Sits between the fetch unit / execute stage (dmem_we, dmem_type from the decoder) and the memory interface.

---
 rtl/mem_port_arbiter.sv | 108 ++++++++++
 tb/tb_mem_port_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between fetch (I) and load/store (D).
// One transaction can be outstanding. D has priority, and a streak limit stops it from starving I.
module mem_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int MEM_TYPE_LEN = 3,
  parameter int STREAK_MAX   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_req,
  input  logic [XLEN-1:0]         i_addr,
  output logic                    i_gnt,
  output logic                    i_rvalid,
  output logic [XLEN-1:0]         i_rdata,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [MEM_TYPE_LEN-1:0] d_type,
  input  logic [XLEN-1:0]         d_addr,
  input  logic [XLEN-1:0]         d_wdata,
  output logic                    d_gnt,
  output logic                    d_rvalid,
  output logic [XLEN-1:0]         d_rdata,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [MEM_TYPE_LEN-1:0] mem_type,
  output logic [XLEN-1:0]         mem_addr,
  output logic [XLEN-1:0]         mem_wdata,
  input  logic                    mem_gnt,
  input  logic                    mem_rvalid,
  input  logic [XLEN-1:0]         mem_rdata,
  output logic                    error
);

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_BUSY} state_t;

  localparam logic [3:0]              SMAX      = 4'(STREAK_MAX);
  localparam logic [MEM_TYPE_LEN-1:0] TYPE_WORD = MEM_TYPE_LEN'(2);

  state_t     state_q, state_d;
  logic       owner_q, owner_d;  // 0 = I, 1 = D
  logic [3:0] streak_q, streak_d;
  logic       error_q, error_d;

  logic win, sel, req_w, accept, resp;

  // Outside IDLE the locked owner drives memory, so a late request cannot preempt it.
  assign win    = d_req && !(i_req && streak_q == SMAX);
  assign sel    = (state_q == S_IDLE) ? win : owner_q;
  assign req_w  = !reset && ((state_q == S_IDLE && (i_req || d_req)) || state_q == S_PEND);
  assign accept = req_w && mem_gnt;
  assign resp   = !reset && state_q == S_BUSY && mem_rvalid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      streak_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    streak_d = streak_q;
    case (state_q)
      S_IDLE: if (req_w) begin
        owner_d = sel;
        state_d = mem_gnt ? S_BUSY : S_PEND;
      end
      S_PEND: if (mem_gnt) state_d = S_BUSY;
      S_BUSY: if (mem_rvalid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      if (sel && i_req) streak_d = (streak_q == SMAX) ? SMAX : streak_q + 4'd1;
      else              streak_d = '0;
    end
    error_d = error_q || (mem_rvalid && state_q != S_BUSY) || (mem_gnt && !req_w);
  end

  always_comb begin
    mem_req   = req_w;
    mem_we    = 1'b0;
    mem_type  = TYPE_WORD;
    mem_addr  = i_addr;
    mem_wdata = '0;
    if (sel) begin
      mem_we    = d_we;
      mem_type  = d_type;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
    i_gnt    = accept && !sel;
    d_gnt    = accept && sel;
    i_rvalid = resp && !owner_q;
    d_rvalid = resp && owner_q;
    i_rdata  = mem_rdata;
    d_rdata  = mem_rdata;
    error    = error_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed test-plan steps followed by randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int SM = 4;

  logic        clk = 0, reset;
  logic        i_req, i_gnt, i_rvalid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [2:0]  d_type;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid, error;
  logic [2:0]  mem_type;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0, failures = 0;

  mem_port_arbiter #(.XLEN(32), .MEM_TYPE_LEN(3), .STREAK_MAX(SM)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_type(d_type), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_type(mem_type), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // model state for the random phase
  bit busy, locked, lock_own, own, win, iw, dw, exp_req, granted;
  int cnt, streak_m;

  initial begin
    reset = 1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_type = 0; d_addr = 0; d_wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    tick(); tick();
    reset = 0; settle();
    chk("rst_mem_req", mem_req, 0); chk("rst_i_gnt", i_gnt, 0); chk("rst_d_gnt", d_gnt, 0);
    chk("rst_rvalid", {i_rvalid, d_rvalid}, 0); chk("rst_error", error, 0);

    // 1: fetch only, zero-wait accept
    tick();
    i_req = 1; i_addr = 32'h100; mem_gnt = 1; settle();
    chk("t1_i_gnt", i_gnt, 1); chk("t1_d_gnt", d_gnt, 0); chk("t1_mem_req", mem_req, 1);
    chk("t1_addr", mem_addr, 32'h100); chk("t1_type", mem_type, 3'b010); chk("t1_we", mem_we, 0);
    tick();
    i_req = 0; mem_gnt = 0; settle();
    chk("t1_busy_req", mem_req, 0);
    tick();
    mem_rvalid = 1; mem_rdata = 32'h13; settle();
    chk("t1_i_rvalid", i_rvalid, 1); chk("t1_i_rdata", i_rdata, 32'h13); chk("t1_d_rvalid", d_rvalid, 0);
    tick();

    // 2: simultaneous I and D store, D first
    mem_rvalid = 0; i_req = 1; i_addr = 32'h104;
    d_req = 1; d_we = 1; d_type = 3'b010; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; mem_gnt = 1; settle();
    chk("t2_d_gnt", d_gnt, 1); chk("t2_i_gnt", i_gnt, 0); chk("t2_we", mem_we, 1);
    chk("t2_addr", mem_addr, 32'h2000); chk("t2_wdata", mem_wdata, 32'hDEADBEEF);
    tick();
    d_req = 0; mem_gnt = 0; mem_rvalid = 1; settle();
    chk("t2_d_rvalid", d_rvalid, 1); chk("t2_i_rvalid", i_rvalid, 0);
    tick();
    mem_rvalid = 0; mem_gnt = 1; settle();
    chk("t2_i_gnt2", i_gnt, 1); chk("t2_addr2", mem_addr, 32'h104); chk("t2_we2", mem_we, 0);
    tick();
    i_req = 0; mem_gnt = 0; mem_rvalid = 1; settle();
    chk("t2_i_rvalid", i_rvalid, 1);
    tick();

    // 3: starvation guard, D x4 then I, twice
    mem_rvalid = 0; i_req = 1; d_req = 1; d_we = 0;
    for (int k = 0; k < 10; k++) begin
      mem_gnt = 1; mem_rvalid = 0; settle();
      chk("t3_i_gnt", i_gnt, (k % 5 == 4));
      chk("t3_d_gnt", d_gnt, (k % 5 != 4));
      tick();
      mem_gnt = 0; mem_rvalid = 1; mem_rdata = k; settle();
      chk("t3_rvalid", {i_rvalid, d_rvalid}, (k % 5 == 4) ? 2'b10 : 2'b01);
      tick();
    end
    mem_rvalid = 0; i_req = 0; d_req = 0;

    // 4: backpressure keeps I locked while D arrives
    i_req = 1; i_addr = 32'h300; d_addr = 32'h4000; mem_gnt = 0;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) d_req = 1;
      settle();
      chk("t4_req", mem_req, 1); chk("t4_addr", mem_addr, 32'h300);
      chk("t4_gnt", {i_gnt, d_gnt}, 0);
      tick();
    end
    mem_gnt = 1; settle();
    chk("t4_i_gnt", i_gnt, 1); chk("t4_d_gnt", d_gnt, 0); chk("t4_addr_g", mem_addr, 32'h300);
    tick();
    i_req = 0; mem_gnt = 0; mem_rvalid = 1; settle();
    chk("t4_i_rvalid", i_rvalid, 1); chk("t4_d_rvalid", d_rvalid, 0);
    tick();
    mem_rvalid = 0; mem_gnt = 1; settle();
    chk("t4_d_gnt2", d_gnt, 1); chk("t4_addr2", mem_addr, 32'h4000);
    tick();
    d_req = 0; mem_gnt = 0; mem_rvalid = 1; settle();
    chk("t4_d_rvalid2", d_rvalid, 1);
    tick();

    // 5: stray response in IDLE
    mem_rvalid = 1; settle();
    chk("t5_no_rvalid", {i_rvalid, d_rvalid}, 0); chk("t5_err_pre", error, 0);
    tick();
    mem_rvalid = 0; settle();
    chk("t5_error", error, 1);
    tick();
    chk("t5_sticky", error, 1);
    reset = 1; tick();
    reset = 0; settle();
    chk("t5_err_clr", error, 0);
    mem_gnt = 1; tick();
    mem_gnt = 0; settle();
    chk("t5_gnt_err", error, 1);
    reset = 1; tick(); reset = 0; settle();
    chk("t5_err_clr2", error, 0);

    // 6: reset while BUSY with D, streak at its limit
    i_req = 1; d_req = 1; i_addr = 32'h500; d_addr = 32'h6000;
    for (int k = 0; k < 4; k++) begin
      mem_gnt = 1; mem_rvalid = 0; settle();
      chk("t6_d_gnt", d_gnt, 1);
      tick();
      mem_gnt = 0;
      if (k < 3) begin mem_rvalid = 1; tick(); end
    end
    reset = 1; mem_rvalid = 1; settle();
    chk("t6_rst_rvalid", {i_rvalid, d_rvalid}, 0);
    tick();
    reset = 0; mem_rvalid = 0; i_req = 0; d_req = 0; settle();
    chk("t6_outs", {mem_req, i_gnt, d_gnt, i_rvalid, d_rvalid, error}, 0);
    i_req = 1; d_req = 1; mem_gnt = 1; settle();
    chk("t6_streak_clr", {i_gnt, d_gnt}, 2'b01);
    tick();
    d_req = 0; mem_gnt = 0; mem_rvalid = 1; tick();
    mem_rvalid = 0; mem_gnt = 1; settle();
    chk("t6_i_gnt", i_gnt, 1);
    tick();
    i_req = 0; mem_gnt = 0; mem_rvalid = 1; settle();
    chk("t6_i_rvalid", i_rvalid, 1);
    tick();
    mem_rvalid = 0;

    // random traffic; streak is 0 after the last I acceptance
    busy = 0; locked = 0; lock_own = 0; own = 0; iw = 0; dw = 0; cnt = 0; streak_m = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!i_req && !iw && $urandom_range(0, 2) == 0) begin
        i_req = 1; i_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_req && !dw && $urandom_range(0, 2) == 0) begin
        d_req = 1; d_we = 1'($urandom); d_type = 3'($urandom); d_addr = $urandom; d_wdata = $urandom;
      end
      mem_gnt = 0; mem_rvalid = 0; exp_req = 0; win = 0;
      if (busy) begin
        cnt--;
        if (cnt == 0) begin mem_rvalid = 1; mem_rdata = $urandom; end
      end else begin
        exp_req = locked || i_req || d_req;
        win = locked ? lock_own : (d_req && !(i_req && streak_m == SM));
        if (exp_req) mem_gnt = 1'($urandom_range(0, 1));
      end
      settle();
      chk("r_mem_req", mem_req, exp_req);
      chk("r_i_gnt", i_gnt, exp_req && mem_gnt && !win);
      chk("r_d_gnt", d_gnt, exp_req && mem_gnt && win);
      chk("r_i_rvalid", i_rvalid, busy && mem_rvalid && !own);
      chk("r_d_rvalid", d_rvalid, busy && mem_rvalid && own);
      if (exp_req) begin
        chk("r_addr", mem_addr, win ? d_addr : i_addr);
        chk("r_we", mem_we, win ? d_we : 1'b0);
        chk("r_type", mem_type, win ? d_type : 3'b010);
        chk("r_wdata", mem_wdata, win ? d_wdata : 32'h0);
      end
      if (mem_rvalid) chk("r_rdata", own ? d_rdata : i_rdata, mem_rdata);
      granted = 0;
      if (busy && mem_rvalid) begin
        busy = 0;
        if (own) dw = 0; else iw = 0;
      end else if (exp_req && mem_gnt) begin
        busy = 1; own = win; locked = 0; granted = 1; cnt = $urandom_range(1, 3);
        if (win && i_req) streak_m = (streak_m < SM) ? streak_m + 1 : SM;
        else              streak_m = 0;
        if (win) dw = 1; else iw = 1;
      end else if (exp_req) begin
        locked = 1; lock_own = win;
      end
      tick();
      if (granted) begin
        if (own) d_req = 0; else i_req = 0;
      end
    end
    mem_gnt = 0; mem_rvalid = 0; settle();
    chk("r_error", error, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
